// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared constants for the phased processor datapath (p1..p5).
//   DATA_W / ADDR_W : datapath width and register index width
//   WB_SRC_*        : writeback source select encoding
//   wb_state_t      : writeback stage state encoding (IDLE / STAGED)
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    typedef enum logic {
        WB_IDLE   = 1'b0,
        WB_STAGED = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Writeback stage: holds the DR latch and the staged destination index,
// and decides when the staged result is committed to the register file.
//
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   p4, p5                  phase strobes (stage / commit)
//   wb_en, wb_sel, wb_addr  writeback request, sampled at p4
//   data_from_alu/mem       writeback source data
//   commit_en               register write strobe for this cycle
//   commit_idx, commit_data register write index and data
//   staged, staged_idx,
//   staged_data             bypass information for the read ports
//   wb_pending              a staged result awaits commit
//   wb_commit               pulses the cycle after a register write
// ---------------------------------------------------------------------------
module wb_stage
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p4,
    input  logic              p5,
    input  logic              wb_en,
    input  logic              wb_sel,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] data_from_alu,
    input  logic [DATA_W-1:0] data_from_mem,
    output logic              commit_en,
    output logic [ADDR_W-1:0] commit_idx,
    output logic [DATA_W-1:0] commit_data,
    output logic              staged,
    output logic [ADDR_W-1:0] staged_idx,
    output logic [DATA_W-1:0] staged_data,
    output logic              wb_pending,
    output logic              wb_commit
);

    wb_state_t         state_q, state_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wb_commit_q, wb_commit_d;
    logic              commit_now;
    logic              stage_now;

    // A staged result is written out on p5, and also on p4 when the p5 for
    // it was missed, so that a new stage never overwrites an uncommitted DR.
    assign commit_now = (state_q == WB_STAGED) && (p4 || p5);
    assign stage_now  = p4 && wb_en;

    always_comb begin
        state_d     = state_q;
        dr_d        = dr_q;
        idx_d       = idx_q;
        wb_commit_d = commit_now;

        if (stage_now) begin
            dr_d    = (wb_sel == WB_SRC_MEM) ? data_from_mem : data_from_alu;
            idx_d   = wb_addr;
            state_d = WB_STAGED;
        end else if (commit_now) begin
            state_d = WB_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= WB_IDLE;
            dr_q        <= '0;
            idx_q       <= '0;
            wb_commit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dr_q        <= dr_d;
            idx_q       <= idx_d;
            wb_commit_q <= wb_commit_d;
        end
    end

    assign commit_en   = commit_now;
    assign commit_idx  = idx_q;
    assign commit_data = dr_q;

    assign staged      = (state_q == WB_STAGED);
    assign staged_idx  = idx_q;
    assign staged_data = dr_q;

    assign wb_pending  = (state_q == WB_STAGED);
    assign wb_commit   = wb_commit_q;

endmodule

// File: rtl/regfile_wb.sv
// ---------------------------------------------------------------------------
// regfile_wb
// General register file plus writeback stage. Two combinational read ports
// feed the AR/BR latches; the writeback stage stages a result at p4 and
// commits it at p5. Uncommitted staged data is bypassed to the read ports.
//
// Ports:
//   clock, reset              clock and asynchronous active-high reset
//   p4, p5                    phase strobes
//   wb_en, wb_sel, wb_addr    writeback request (sampled at p4)
//   data_from_ALU/mem         writeback sources
//   ra_addr, rb_addr          read port indices
//   data_to_AR, data_to_BR    read port data (combinational)
//   wb_pending                staged result awaiting commit
//   wb_commit                 one-cycle pulse after a register write
// ---------------------------------------------------------------------------
module regfile_wb
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int NREG   = proc_pkg::NREG,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p4,
    input  logic              p5,
    input  logic              wb_en,
    input  logic              wb_sel,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] data_from_ALU,
    input  logic [DATA_W-1:0] data_from_mem,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] data_to_AR,
    output logic [DATA_W-1:0] data_to_BR,
    output logic              wb_pending,
    output logic              wb_commit
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    logic              commit_en;
    logic [ADDR_W-1:0] commit_idx;
    logic [DATA_W-1:0] commit_data;
    logic              staged;
    logic [ADDR_W-1:0] staged_idx;
    logic [DATA_W-1:0] staged_data;

    wb_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_stage (
        .clock         (clock),
        .reset         (reset),
        .p4            (p4),
        .p5            (p5),
        .wb_en         (wb_en),
        .wb_sel        (wb_sel),
        .wb_addr       (wb_addr),
        .data_from_alu (data_from_ALU),
        .data_from_mem (data_from_mem),
        .commit_en     (commit_en),
        .commit_idx    (commit_idx),
        .commit_data   (commit_data),
        .staged        (staged),
        .staged_idx    (staged_idx),
        .staged_data   (staged_data),
        .wb_pending    (wb_pending),
        .wb_commit     (wb_commit)
    );

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit_en) begin
            regs_d[commit_idx] = commit_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // While a result is staged, DR is the newest value of its register, so a
    // matching read takes DR. This also covers the commit cycle itself, when
    // the array has not yet been updated.
    always_comb begin
        data_to_AR = regs_q[ra_addr];
        data_to_BR = regs_q[rb_addr];
        if (staged && (ra_addr == staged_idx)) begin
            data_to_AR = staged_data;
        end
        if (staged && (rb_addr == staged_idx)) begin
            data_to_BR = staged_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb
// Directed self-checking bench for regfile_wb.
// ---------------------------------------------------------------------------
module tb_regfile_wb;

    logic        clock;
    logic        reset;
    logic        p4;
    logic        p5;
    logic        wb_en;
    logic        wb_sel;
    logic [2:0]  wb_addr;
    logic [15:0] data_from_ALU;
    logic [15:0] data_from_mem;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic [15:0] data_to_AR;
    logic [15:0] data_to_BR;
    logic        wb_pending;
    logic        wb_commit;

    int checks;
    int failures;

    regfile_wb dut (
        .clock         (clock),
        .reset         (reset),
        .p4            (p4),
        .p5            (p5),
        .wb_en         (wb_en),
        .wb_sel        (wb_sel),
        .wb_addr       (wb_addr),
        .data_from_ALU (data_from_ALU),
        .data_from_mem (data_from_mem),
        .ra_addr       (ra_addr),
        .rb_addr       (rb_addr),
        .data_to_AR    (data_to_AR),
        .data_to_BR    (data_to_BR),
        .wb_pending    (wb_pending),
        .wb_commit     (wb_commit)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a p4 stage request for one cycle.
    task automatic stage(input logic sel, input logic [2:0] addr,
                         input logic [15:0] alu, input logic [15:0] mem);
        p4 = 1'b1; wb_en = 1'b1; wb_sel = sel; wb_addr = addr;
        data_from_ALU = alu; data_from_mem = mem;
        tick();
        p4 = 1'b0; wb_en = 1'b0;
    endtask

    task automatic commit();
        p5 = 1'b1;
        tick();
        p5 = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; p4 = 1'b0; p5 = 1'b0; wb_en = 1'b0; wb_sel = 1'b0;
        wb_addr = 3'd0; data_from_ALU = 16'h0; data_from_mem = 16'h0;
        ra_addr = 3'd0; rb_addr = 3'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        ra_addr = 3'd3; rb_addr = 3'd5; #1;
        check("rst_AR", data_to_AR, 16'h0000);
        check("rst_BR", data_to_BR, 16'h0000);
        check("rst_pending", {15'd0, wb_pending}, 16'd0);
        check("rst_commit", {15'd0, wb_commit}, 16'd0);

        // ALU writeback to r2, with bypass while staged
        stage(1'b0, 3'd2, 16'h1234, 16'hDEAD);
        ra_addr = 3'd2; rb_addr = 3'd3; #1;
        check("alu_pending", {15'd0, wb_pending}, 16'd1);
        check("alu_bypass_AR", data_to_AR, 16'h1234);
        check("alu_other_BR", data_to_BR, 16'h0000);
        check("alu_commit_early", {15'd0, wb_commit}, 16'd0);
        commit();
        check("alu_commit_pulse", {15'd0, wb_commit}, 16'd1);
        check("alu_pending_clr", {15'd0, wb_pending}, 16'd0);
        check("alu_r2", data_to_AR, 16'h1234);
        tick();
        check("alu_commit_once", {15'd0, wb_commit}, 16'd0);

        // Memory writeback to r7
        stage(1'b1, 3'd7, 16'h0001, 16'hBEEF);
        rb_addr = 3'd7; #1;
        check("mem_bypass_BR", data_to_BR, 16'hBEEF);
        commit();
        tick();
        check("mem_r7", data_to_BR, 16'hBEEF);
        check("mem_pending", {15'd0, wb_pending}, 16'd0);

        // Simultaneous p4/p5, same destination r1
        stage(1'b0, 3'd1, 16'hAAAA, 16'h0);
        p4 = 1'b1; p5 = 1'b1; wb_en = 1'b1; wb_sel = 1'b0; wb_addr = 3'd1;
        data_from_ALU = 16'h5555;
        tick();
        p4 = 1'b0; p5 = 1'b0; wb_en = 1'b0;
        ra_addr = 3'd1; #1;
        check("both_commit_pulse", {15'd0, wb_commit}, 16'd1);
        check("both_pending", {15'd0, wb_pending}, 16'd1);
        check("both_bypass_r1", data_to_AR, 16'h5555);
        commit();
        tick();
        check("both_r1_final", data_to_AR, 16'h5555);

        // Simultaneous p4/p5, different destination: old result visible in array
        stage(1'b0, 3'd1, 16'hAAAA, 16'h0);
        p4 = 1'b1; p5 = 1'b1; wb_en = 1'b1; wb_addr = 3'd0; data_from_ALU = 16'hC3C3;
        tick();
        p4 = 1'b0; p5 = 1'b0; wb_en = 1'b0;
        ra_addr = 3'd1; rb_addr = 3'd0; #1;
        check("both_r1_committed", data_to_AR, 16'hAAAA);
        check("both_r0_bypass", data_to_BR, 16'hC3C3);
        commit();

        // Missed commit: second p4 commits the first result
        stage(1'b0, 3'd3, 16'h1111, 16'h0);
        stage(1'b1, 3'd5, 16'h0, 16'h2222);
        ra_addr = 3'd3; rb_addr = 3'd5; #1;
        check("miss_commit_pulse", {15'd0, wb_commit}, 16'd1);
        check("miss_r3", data_to_AR, 16'h1111);
        check("miss_r5_bypass", data_to_BR, 16'h2222);
        check("miss_pending", {15'd0, wb_pending}, 16'd1);
        commit();
        tick();
        check("miss_r5", data_to_BR, 16'h2222);

        // Reset while a result is staged
        stage(1'b0, 3'd4, 16'h00FF, 16'h0);
        reset = 1'b1; #1;
        ra_addr = 3'd4; rb_addr = 3'd7; #1;
        check("rst_mid_r4", data_to_AR, 16'h0000);
        check("rst_mid_r7", data_to_BR, 16'h0000);
        check("rst_mid_pending", {15'd0, wb_pending}, 16'd0);
        tick();
        reset = 1'b0;
        commit();
        check("rst_mid_p5_commit", {15'd0, wb_commit}, 16'd0);
        check("rst_mid_p5_r4", data_to_AR, 16'h0000);

        // p4 without wb_en leaves r6 and the stage untouched
        stage(1'b0, 3'd6, 16'h0F0F, 16'h0);
        commit();
        tick();
        p4 = 1'b1; wb_en = 1'b0; wb_addr = 3'd6; data_from_ALU = 16'hFFFF;
        tick();
        p4 = 1'b0;
        ra_addr = 3'd6; #1;
        check("noen_pending", {15'd0, wb_pending}, 16'd0);
        commit();
        check("noen_commit", {15'd0, wb_commit}, 16'd0);
        check("noen_r6", data_to_AR, 16'h0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Register file plus writeback stage for the phased processor (p1..p5).
- Supplies the operand read data that the AR/BR latches capture at p3.
- Captures the writeback result (ALU or memory) into an internal DR latch at p4.
- Commits the DR latch into the destination register at p5.
- Bypasses pending (staged, uncommitted) writeback data to the read ports.

Parameters:
- DATA_W, 16, width of registers and data paths.
- NREG, 8, number of general registers.
- ADDR_W, 3, register index width; NREG equals 2**ADDR_W.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; formats all state.
- p4  input  1  phase-4 strobe; stage the writeback result.
- p5  input  1  phase-5 strobe; commit the staged result.
- wb_en  input  1  instruction writes a register; sampled at p4 only.
- wb_sel  input  1  writeback source: 0 = data_from_ALU, 1 = data_from_mem; sampled at p4.
- wb_addr  input  ADDR_W  destination register index; sampled at p4.
- data_from_ALU  input  DATA_W  ALU result.
- data_from_mem  input  DATA_W  memory load data.
- ra_addr  input  ADDR_W  read port A index (toward AR).
- rb_addr  input  ADDR_W  read port B index (toward BR).
- data_to_AR  output  DATA_W  read port A data, combinational.
- data_to_BR  output  DATA_W  read port B data, combinational.
- wb_pending  output  1  high while a staged result awaits commit.
- wb_commit  output  1  one-cycle pulse in the cycle after a register was written.

Behaviour:
- Reset (asynchronous): all NREG registers = 0; DR = 0; staged index = 0; state = IDLE; wb_pending = 0; wb_commit = 0.
- Read ports with state IDLE: data_to_AR = reg[ra_addr], data_to_BR = reg[rb_addr].
- Read ports with state STAGED: if the read index equals the staged index, the port returns DR (bypass); otherwise it returns the register.
- State machine has two states, IDLE and STAGED. wb_pending = (state == STAGED).
- IDLE, p4=1, wb_en=1:
  - DR <= selected source; staged index <= wb_addr; next state STAGED.
- IDLE, p4=1, wb_en=0: no state change. DR holds its previous value.
- IDLE, p5=1: no register write; wb_commit stays 0.
- STAGED, p5=1, p4=0:
  - reg[staged index] <= DR; next state IDLE.
  - wb_commit = 1 in the following cycle.
- STAGED, p4=1 and p5=1 in the same cycle:
  - Commit the old DR to the old index.
  - Stage the new result if wb_en=1 (stay STAGED); otherwise go IDLE.
  - wb_commit pulses.
- STAGED, p4=1, p5=0 (missed commit):
  - Commit the old DR first, then stage the new result if wb_en=1.
  - No staged write is ever dropped.
- STAGED, neither strobe high: hold all state.
- wb_commit is registered. It is high exactly one cycle after each register write and 0 otherwise.
- Source mux is DATA_W wide; no width conversion, sign or zero extension.
- All indices are used modulo NREG.
- Reset asserted mid-STAGED: the pending write is discarded and all registers return to 0.
- The block does not decode phases and does not check phase ordering.

Decomposition:
- Shared package (proc_pkg) holds:
  - DATA_W and ADDR_W constants.
  - WB_SRC_ALU = 1'b0 and WB_SRC_MEM = 1'b1.
  - The IDLE/STAGED state encoding.
- Sub-module wb_stage (one natural split) contains:
  - The DR latch, staged index, state FSM, and the wb_pending/wb_commit logic.
  - Outputs: commit strobe, commit index, commit data.
- regfile_wb contains the register array, the write port, and the bypass read muxes.

Test Plan:
- Reset then read ra_addr=3, rb_addr=5 -> data_to_AR = data_to_BR = 0x0000; wb_pending=0, wb_commit=0.
- p4 with wb_en=1, wb_sel=0, wb_addr=2, ALU=0x1234 -> wb_pending=1, ra_addr=2 returns 0x1234 (bypass). Then p5 -> reg2 = 0x1234, wb_commit pulses one cycle, wb_pending=0.
- p4 with wb_en=1, wb_sel=1, wb_addr=7, mem=0xBEEF, ALU=0x0001 -> after p5, rb_addr=7 reads 0xBEEF.
- Staged 0xAAAA to r1; next p4 and p5 in the same cycle, staging 0x5555 to r1 -> r1 = 0xAAAA committed; bypass now returns 0x5555; after the next p5, r1 = 0x5555.
- Staged 0x00FF to r4; assert reset before p5 -> r4 = 0, wb_pending=0, and a later p5 writes nothing.
- p4 with wb_en=0 (r6 holds 0x0F0F), then p5 -> r6 unchanged; wb_commit stays 0.
